// File: rtl/loader_pkg.sv
// ----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the boot-time program loader.
//   state_t        : loader FSM states
//   HEADER_BYTES   : count bytes that precede the payload
//   BYTES_PER_WORD : bytes packed into each instruction word
//   COUNT_WIDTH    : width of the word-count field in the header
//   rx_ready_for() : the states in which the loader accepts stream bytes
// ----------------------------------------------------------------------------
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COUNT_LO,
      COUNT_HI,
      DATA,
      CHECK,
      DONE_ST,
      ERROR_ST
   } state_t;

   localparam int HEADER_BYTES   = 2;
   localparam int BYTES_PER_WORD = 4;
   localparam int COUNT_WIDTH    = 16;

   // The stream is accepted in every state that consumes a byte of the
   // stream, and in no other state.
   function automatic logic rx_ready_for(input state_t s);
      return s inside {COUNT_LO, COUNT_HI, DATA, CHECK};
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// ----------------------------------------------------------------------------
// program_loader_if
// Groups the byte-stream handshake and the instruction-memory write port.
//   RX_DATA / RX_VALID / RX_READY : byte stream into the loader
//   IM_WE / IM_ADDR / IM_DATA     : one-word-per-strobe instruction-memory write
// Modports:
//   master : stream source and memory side (drives RX_DATA, RX_VALID)
//   slave  : the loader (drives RX_READY and the memory write port)
// ----------------------------------------------------------------------------
interface program_loader_if #(
   parameter int ADDR_WIDTH = 10
);

   logic [7:0]            RX_DATA;
   logic                  RX_VALID;
   logic                  RX_READY;
   logic                  IM_WE;
   logic [ADDR_WIDTH-1:0] IM_ADDR;
   logic [31:0]           IM_DATA;

   modport master (
      output RX_DATA, RX_VALID,
      input  RX_READY, IM_WE, IM_ADDR, IM_DATA
   );

   modport slave (
      input  RX_DATA, RX_VALID,
      output RX_READY, IM_WE, IM_ADDR, IM_DATA
   );

endinterface

// File: rtl/loader_byte_pack.sv
// ----------------------------------------------------------------------------
// loader_byte_pack
// Packs accepted stream bytes into 32-bit little-endian words {b3,b2,b1,b0}.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : restart at lane 0 (used when a new load is armed)
//   accept     : rx_byte is consumed this cycle
//   rx_byte    : stream byte
//   word_ready : lane 3 is being accepted this cycle (one-cycle strobe)
//   word       : complete word, valid while word_ready is high
// ----------------------------------------------------------------------------
module loader_byte_pack
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  rx_byte,
   output logic        word_ready,
   output logic [31:0] word
);

   localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  lane;
   // Only lanes 0..2 need storage: lane 3 is taken straight from the input
   // so the word is available in the same cycle its last byte arrives.
   logic [23:0] pack;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane <= '0;
         pack <= '0;
      end else if (clear) begin
         lane <= '0;
         pack <= '0;
      end else if (accept) begin
         lane <= lane + 2'd1;
         case (lane)
            2'd0:    pack[7:0]   <= rx_byte;
            2'd1:    pack[15:8]  <= rx_byte;
            2'd2:    pack[23:16] <= rx_byte;
            default: ;
         endcase
      end
   end

   assign word_ready = accept && (lane == LAST_LANE);
   assign word       = {rx_byte, pack};

endmodule

// File: rtl/program_loader.sv
// ----------------------------------------------------------------------------
// program_loader
// Boot-time writer for the CPU instruction memory. Parses a byte stream of
// count_lo, count_hi, 4*N data bytes and an XOR checksum byte, writes each
// packed word to instruction memory and releases the CPU only after the
// checksum matches.
//   CLOCK, RESET  : clock, asynchronous active-high reset
//   START         : one-cycle pulse arming a load (ignored while BUSY)
//   bus           : stream handshake and instruction-memory write port
//   CPU_RESET     : held high until a load completes cleanly
//   CPU_ENABLE    : high only after a clean load
//   BUSY          : load in progress
//   DONE / ERROR  : outcome of the last load
//   WORDS_LOADED  : words written in the current or last load
// ----------------------------------------------------------------------------
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic                  START,
   program_loader_if.slave       bus,
   output logic                  CPU_RESET,
   output logic                  CPU_ENABLE,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERROR,
   output logic [ADDR_WIDTH:0]   WORDS_LOADED
);

   // Capacity in words; one bit wider than the count so 2^16 is representable.
   localparam logic [COUNT_WIDTH:0] MAX_WORDS = (COUNT_WIDTH + 1)'(2 ** ADDR_WIDTH);

   state_t                 state;
   state_t                 state_nxt;
   logic                   rx_ready;
   logic                   transfer;
   logic                   data_accept;
   logic                   arm;
   logic                   enter_done;
   logic                   enter_error;
   logic                   word_ready;
   logic [31:0]            packed_word;
   logic [COUNT_WIDTH-1:0] count;
   logic [COUNT_WIDTH-1:0] count_rx;
   logic                   count_too_big;
   logic                   last_word;
   logic [7:0]             xor_acc;
   logic                   im_we;
   logic [ADDR_WIDTH-1:0]  im_addr;
   logic [31:0]            im_data;

   assign rx_ready    = rx_ready_for(state);
   assign transfer    = bus.RX_VALID && rx_ready;
   assign data_accept = transfer && (state == DATA);

   // Full count as it will be once the high byte currently on the bus lands.
   assign count_rx      = {bus.RX_DATA, count[7:0]};
   assign count_too_big = {1'b0, count_rx} > MAX_WORDS;
   // The word being completed now is the last one when it brings the total to N.
   assign last_word     = ((COUNT_WIDTH + 1)'(WORDS_LOADED) + 1'b1) == {1'b0, count};

   assign bus.RX_READY = rx_ready;
   assign bus.IM_WE    = im_we;
   assign bus.IM_ADDR  = im_addr;
   assign bus.IM_DATA  = im_data;

   loader_byte_pack u_pack (
      .clk        (CLOCK),
      .rst        (RESET),
      .clear      (arm),
      .accept     (data_accept),
      .rx_byte    (bus.RX_DATA),
      .word_ready (word_ready),
      .word       (packed_word)
   );

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every signal written here gets a default first; a path that left
   // one unassigned would infer a latch.
   always_comb begin
      state_nxt   = state;
      arm         = 1'b0;
      enter_done  = 1'b0;
      enter_error = 1'b0;
      case (state)
         IDLE, DONE_ST, ERROR_ST: begin
            if (START) begin
               state_nxt = COUNT_LO;
               arm       = 1'b1;
            end
         end
         COUNT_LO: begin
            if (transfer) state_nxt = COUNT_HI;
         end
         COUNT_HI: begin
            if (transfer) begin
               if (count_too_big) begin
                  state_nxt   = ERROR_ST;
                  enter_error = 1'b1;
               end else if (count_rx == '0) begin
                  state_nxt = CHECK;
               end else begin
                  state_nxt = DATA;
               end
            end
         end
         DATA: begin
            if (word_ready && last_word) state_nxt = CHECK;
         end
         CHECK: begin
            if (transfer) begin
               if (bus.RX_DATA == xor_acc) begin
                  state_nxt  = DONE_ST;
                  enter_done = 1'b1;
               end else begin
                  state_nxt   = ERROR_ST;
                  enter_error = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         count        <= '0;
         xor_acc      <= '0;
         im_we        <= 1'b0;
         im_addr      <= '0;
         im_data      <= '0;
         WORDS_LOADED <= '0;
         CPU_RESET    <= 1'b1;
         CPU_ENABLE   <= 1'b0;
         BUSY         <= 1'b0;
         DONE         <= 1'b0;
         ERROR        <= 1'b0;
      end else begin
         im_we <= 1'b0;

         if (arm) begin
            xor_acc      <= '0;
            WORDS_LOADED <= '0;
            CPU_RESET    <= 1'b1;
            CPU_ENABLE   <= 1'b0;
            BUSY         <= 1'b1;
            DONE         <= 1'b0;
            ERROR        <= 1'b0;
         end

         // Header and payload bytes feed the running XOR; the checksum does not.
         if (transfer && state != CHECK) xor_acc <= xor_acc ^ bus.RX_DATA;

         if (transfer && state == COUNT_LO) count[7:0] <= bus.RX_DATA;
         if (transfer && state == COUNT_HI) count[15:8] <= bus.RX_DATA;

         // Registered write keeps RX_READY high, so a new word can start
         // packing while the previous one is being written.
         if (word_ready) begin
            im_we        <= 1'b1;
            im_addr      <= WORDS_LOADED[ADDR_WIDTH-1:0];
            im_data      <= packed_word;
            WORDS_LOADED <= WORDS_LOADED + 1'b1;
         end

         if (enter_done) begin
            BUSY       <= 1'b0;
            DONE       <= 1'b1;
            CPU_RESET  <= 1'b0;
            CPU_ENABLE <= 1'b1;
         end

         // CPU stays held in reset: partially written memory must not run.
         if (enter_error) begin
            BUSY  <= 1'b0;
            ERROR <= 1'b1;
         end
      end
   end

endmodule
